seq_addsub: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor. Processes CHUNK bits per cycle, LSB chunk first.

---
 rtl/seq_addsub_if.sv | 30 +++
 rtl/seq_addsub.sv | 147 ++++++++++++++
 tb/tb_seq_addsub.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/seq_addsub_if.sv
// Handshake bundle for seq_addsub.
//   Operand side : in_valid, in_ready, data0 (A), data1 (B), mode (1 = add, 0 = subtract)
//   Result side  : out_valid, out_ready, final_sum, final_carry_out, overflow
// Modports:
//   master - operand producer / result consumer (drives in_valid, data0, data1, mode, out_ready)
//   slave  - the adder/subtractor (drives in_ready, out_valid, final_sum, final_carry_out, overflow)
interface seq_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] final_sum;
    logic             final_carry_out;
    logic             overflow;

    modport master (
        output in_valid, data0, data1, mode, out_ready,
        input  in_ready, out_valid, final_sum, final_carry_out, overflow
    );

    modport slave (
        input  in_valid, data0, data1, mode, out_ready,
        output in_ready, out_valid, final_sum, final_carry_out, overflow
    );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle two's-complement adder/subtractor.
// Processes CHUNK bits per cycle, LSB chunk first, with a registered carry between chunks.
// One operation takes NCHUNK = WIDTH/CHUNK cycles from the accepting edge to out_valid.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - seq_addsub_if.slave: operand handshake (in_valid/in_ready, data0, data1, mode)
//          and result handshake (out_valid/out_ready, final_sum, final_carry_out, overflow)
// Configuration:
//   ADDSUB_SATURATE_EN - when defined, final_sum saturates on signed overflow; overflow and
//                        final_carry_out still report the raw values.
module seq_addsub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input logic         clk,
    input logic         rst,
    seq_addsub_if.slave bus
);
    localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned REMW   = (CHUNK == 0) ? 1 : WIDTH % CHUNK;

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || REMW != 0) begin : g_bad_param
        $error("seq_addsub: illegal WIDTH=%0d / CHUNK=%0d", WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] acc_full;
    logic [WIDTH-1:0] result_sum;
    logic             msb_cin;
    logic             raw_cout;
    logic             raw_ovf;
    logic             last_chunk;

    // Chunk datapath: one CHUNK-bit adder shared by every cycle of the operation.
    always_comb begin
        chunk_a   = a_q[idx_q*CHUNK +: CHUNK];
        chunk_b   = b_q[idx_q*CHUNK +: CHUNK];
        chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        acc_full  = acc_q;
        acc_full[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        raw_cout  = chunk_res[CHUNK];
        // Carry into the MSB recovered from the MSB sum bit of the final chunk's adder.
        msb_cin   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ acc_full[WIDTH-1];
        raw_ovf   = msb_cin ^ raw_cout;
        last_chunk = (idx_q == IDXW'(NCHUNK - 1));
`ifdef ADDSUB_SATURATE_EN
        if (raw_ovf) begin
            // Carry out 0 on overflow means two positives wrapped negative.
            result_sum = raw_cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            result_sum = acc_full;
        end
`else
        result_sum = acc_full;
`endif
    end

    // Next-state and register updates.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.data0;
                    // Subtract is A + ~B + 1: invert B here, seed the carry with ~mode.
                    b_d     = bus.mode ? bus.data1 : ~bus.data1;
                    carry_d = ~bus.mode;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d   = acc_full;
                carry_d = raw_cout;
                if (last_chunk) begin
                    sum_d   = result_sum;
                    cout_d  = raw_cout;
                    ovf_d   = raw_ovf;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready        = (state_q == StIdle);
    assign bus.out_valid       = (state_q == StDone);
    assign bus.final_sum       = sum_q;
    assign bus.final_carry_out = cout_q;
    assign bus.overflow        = ovf_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed vectors, stalled result handshake, reset
// mid-operation and randomized operations against an arithmetic reference model.
module tb_seq_addsub;
    localparam int unsigned W      = 8;
    localparam int unsigned C      = 2;
    localparam int unsigned NCHUNK = W / C;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_addsub_if #(.WIDTH(W)) bus ();

    seq_addsub #(
        .WIDTH (W),
        .CHUNK (C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic on the operand values.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         output logic [W-1:0] s, output logic c, output logic v);
        longint sa, sb, r, ua, ub;
        logic [63:0] rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = m ? sa + sb : sa - sb;
        c  = m ? ((ua + ub) >= (longint'(1) << W)) : (ua >= ub);
        v  = (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
        rv = r;
        s  = rv[W-1:0];
`ifdef ADDSUB_SATURATE_EN
        if (v) s = (r > 0) ? W'((longint'(1) << (W - 1)) - 1) : W'(longint'(1) << (W - 1));
`endif
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                          input int stall);
        logic [W-1:0] es;
        logic         ec, ev;
        int           lat;
        model(a, b, m, es, ec, ev);
        @(negedge clk);
        chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.data0    = a;
        bus.data1    = b;
        bus.mode     = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.data0    = W'($urandom);
        bus.data1    = W'($urandom);
        bus.mode     = 1'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < int'(NCHUNK) + 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(NCHUNK));
        chk("final_sum", 64'(bus.final_sum), 64'(es));
        chk("final_carry_out", 64'(bus.final_carry_out), 64'(ec));
        chk("overflow", 64'(bus.overflow), 64'(ev));
        chk("in_ready_done", 64'(bus.in_ready), 64'd0);
        // Stall the consumer while offering a competing operation; it must be ignored.
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("stall_sum", 64'(bus.final_sum), 64'(es));
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("valid_drop", 64'(bus.out_valid), 64'd0);
        chk("back_idle", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data0     = '0;
        bus.data1     = '0;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sum", 64'(bus.final_sum), 64'd0);
        chk("rst_carry", 64'(bus.final_carry_out), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);

        run_op(8'h64, 8'h1B, 1'b1, 0);
        run_op(8'h7F, 8'h01, 1'b1, 0);
        run_op(8'h05, 8'h03, 1'b0, 0);
        run_op(8'h03, 8'h05, 1'b0, 1);
        run_op(8'h80, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b1, 5);
        run_op(8'h80, 8'h80, 1'b1, 2);
        run_op(8'h00, 8'h00, 1'b0, 0);

        // Reset during CALC: operation aborted, no result, outputs cleared.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.data0    = 8'h7F;
        bus.data1    = 8'h7F;
        bus.mode     = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (NCHUNK >= 2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort_sum", 64'(bus.final_sum), 64'd0);
        chk("abort_carry", 64'(bus.final_carry_out), 64'd0);
        chk("abort_ovf", 64'(bus.overflow), 64'd0);
        for (int i = 0; i < int'(NCHUNK) + 2; i++) begin
            chk("abort_no_valid", 64'(bus.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 60; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
